// File: rtl/config_loader_if.sv
// Configuration stream interface for config_loader.
// Groups the frame control, stream handshake, status pulses and the committed
// configuration vector.
//   master : drives cfg_start / cfg_in_valid / cfg_in_data, observes the rest
//   slave  : the loader side
interface config_loader_if #(
    parameter int unsigned CFG_W = 88,
    parameter int unsigned DW    = 8
) ();
    logic             cfg_start;
    logic             cfg_in_valid;
    logic [DW-1:0]    cfg_in_data;
    logic             cfg_in_ready;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;
    logic [CFG_W-1:0] c;

    modport master (
        output cfg_start, cfg_in_valid, cfg_in_data,
        input  cfg_in_ready, cfg_busy, cfg_done, cfg_err, c
    );

    modport slave (
        input  cfg_start, cfg_in_valid, cfg_in_data,
        output cfg_in_ready, cfg_busy, cfg_done, cfg_err, c
    );
endinterface

// File: rtl/config_loader.sv
// config_loader: assembles a framed configuration stream into a staging
// register, verifies an XOR checksum, then commits the whole image to `c`
// in a single edge so the connection block never sees a partial image.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (c returns to all-open, i.e. 0)
//   bus   : config_loader_if.slave
//           cfg_start    in  : pulse, begins (or restarts) a frame
//           cfg_in_valid in  : stream word valid
//           cfg_in_data  in  : stream word (DW bits), word 0 is the LSB word
//           cfg_in_ready out : word accepted on edge when valid && ready
//           cfg_busy     out : frame in progress
//           cfg_done     out : one-cycle pulse, image committed to c
//           cfg_err      out : one-cycle pulse, checksum mismatch, c unchanged
//           c            out : committed configuration vector (CFG_W bits)
module config_loader #(
    parameter int unsigned CFG_W = 88,
    parameter int unsigned DW    = 8
) (
    input logic            clk,
    input logic            rst_n,
    config_loader_if.slave bus
);

    localparam int unsigned NWORDS = (CFG_W + DW - 1) / DW;
    localparam int unsigned PAD_W  = NWORDS * DW;
    localparam int unsigned CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    xor_q, xor_d;
    logic [CFG_W-1:0] stage_q, stage_d;
    logic [CFG_W-1:0] c_q, c_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic [PAD_W-1:0] stage_pad;
    logic [31:0]      wr_base;

    assign bus.cfg_in_ready = (state_q != StIdle) && !bus.cfg_start;
    assign bus.cfg_busy     = (state_q != StIdle);
    assign bus.cfg_done     = done_q;
    assign bus.cfg_err      = err_q;
    assign bus.c            = c_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        xor_d     = xor_q;
        stage_d   = stage_q;
        c_d       = c_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        accept    = bus.cfg_in_valid && bus.cfg_in_ready;
        // Staging is widened to a whole number of words so the last word can be
        // written in one slice; bits at or above CFG_W fall off on truncation.
        stage_pad = PAD_W'(stage_q);
        wr_base   = 32'(cnt_q) * DW;

        if (bus.cfg_start) begin
            // Start (or restart) a frame; partial staging is simply overwritten.
            state_d = StLoad;
            cnt_d   = '0;
            xor_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    if (accept) begin
                        stage_pad[wr_base +: DW] = bus.cfg_in_data;
                        stage_d = stage_pad[CFG_W-1:0];
                        // Pad bits are still part of the checksum.
                        xor_d   = xor_q ^ bus.cfg_in_data;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (accept) begin
                        state_d = StIdle;
                        if (bus.cfg_in_data == xor_q) begin
                            c_d    = stage_q;
                            done_d = 1'b1;
                        end else begin
                            err_d  = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            xor_q   <= '0;
            stage_q <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xor_q   <= xor_d;
            stage_q <= stage_d;
            c_q     <= c_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
